// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with valid/ready handshake.
// Eight bitwise ops on WIDTH-bit operands, one-cycle latency, an accumulator
// selectable as operand A, and registered zero/negative status flags.
// Optional feature macro: LOGIC_UNIT_PARITY_EN adds a registered flag_parity
// output (XOR-reduction of the result, 1 = odd number of ones).
module logic_unit_pipe #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic [WIDTH-1:0] acc_q
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             flag_parity
`endif
);

    logic             valid_reg;
    logic [WIDTH-1:0] z_reg;
    logic             zero_reg;
    logic             neg_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] result;
    logic             accept;

    // A new operand set may enter whenever the result slot is empty or is
    // being drained this same cycle; in_valid never gates readiness.
    assign in_ready = !valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // Operand A comes from the accumulator when requested; since the
    // accumulator loads on the accepting edge, chained ops need no bubble.
    assign opnd_a = acc_sel ? acc_reg : a;

    // Each result bit is an 8-entry truth-table lookup indexed by op.
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
        logic [7:0] bit_tt;
        assign bit_tt = {
            b[gi],                        // 111 pass B
            ~opnd_a[gi],                  // 110 not A
            ~(opnd_a[gi] ^ b[gi]),        // 101 xnor
            ~(opnd_a[gi] | b[gi]),        // 100 nor
            ~(opnd_a[gi] & b[gi]),        // 011 nand
            opnd_a[gi] ^ b[gi],           // 010 xor
            opnd_a[gi] | b[gi],           // 001 or
            opnd_a[gi] & b[gi]            // 000 and
        };
        assign result[gi] = bit_tt[op];
    end

    // Result, flags and accumulator load together on accept; a drain with no
    // new accept only clears out_valid, leaving data and flags untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            z_reg     <= '0;
            zero_reg  <= 1'b0;
            neg_reg   <= 1'b0;
            acc_reg   <= ACC_INIT;
        end else if (accept) begin
            valid_reg <= 1'b1;
            z_reg     <= result;
            zero_reg  <= (result == '0);
            neg_reg   <= result[WIDTH-1];
            acc_reg   <= result;
        end else if (valid_reg && out_ready) begin
            valid_reg <= 1'b0;
        end
    end

`ifdef LOGIC_UNIT_PARITY_EN
    logic parity_reg;

    // Parity is registered alongside out_z so it always describes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else if (accept) begin
            parity_reg <= ^result;
        end
    end

    assign flag_parity = parity_reg;
`endif

    assign out_valid = valid_reg;
    assign out_z     = z_reg;
    assign flag_zero = zero_reg;
    assign flag_neg  = neg_reg;
    assign acc_q     = acc_reg;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit for the CPU datapath. It is the successor to the fixed 8-bit combinational gates.
- Eight selectable bitwise ops, one-cycle-latency output register with valid/ready handshake, an internal accumulator usable as operand A, and zero/negative status flags.
- Sits between the register-file read ports and the writeback/flag logic.

Parameters:
- WIDTH, 8, operand/result width in bits (legal >= 2).
- ACC_INIT, 0, accumulator value loaded on reset (WIDTH bits, zero-extended/truncated).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept this cycle.
- op  input  3  operation select (see Behaviour).
- acc_sel  input  1  1 = operand A taken from accumulator instead of port a.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result register holds unconsumed result.
- out_ready  input  1  downstream accepts result.
- out_z  output  WIDTH  registered result.
- flag_zero  output  1  registered: out_z == 0.
- flag_neg  output  1  registered: out_z[WIDTH-1].
- acc_q  output  WIDTH  current accumulator value.
- flag_parity  output  1  present only with LOGIC_UNIT_PARITY_EN.

Behaviour:
- Reset is synchronous, active-high, on clk rising edge. It applies regardless of in_valid/out_ready and discards any held result.
- Reset values: out_valid=0, out_z=0, flag_zero=0, flag_neg=0, flag_parity=0, acc_q=ACC_INIT.
- in_ready = !out_valid || out_ready (combinational). It is never gated by in_valid.
- Accept condition: in_valid && in_ready at the rising edge.
- Operand A = acc_sel ? acc_q : a, sampled at accept.
- Op encoding:
  - 000 A&B
  - 001 A|B
  - 010 A^B
  - 011 ~(A&B)
  - 100 ~(A|B)
  - 101 ~(A^B)
  - 110 ~A (B ignored)
  - 111 B (pass, A ignored)
- All ops are pure bitwise, WIDTH bits; no carry, no sign extension.
- On accept:
  - out_z, flags and acc_q all load the result on the same edge; out_valid <= 1.
  - Latency: 1 cycle from accept to out_valid.
- Consume without new accept (out_valid && out_ready && !(in_valid)): out_valid <= 0. out_z, flags and acc_q hold their last values.
- Stall (out_valid && !out_ready): in_ready=0. out_z, flags, acc_q hold stable; inputs are ignored.
- Simultaneous consume+accept: the new result replaces the old on the same edge, out_valid stays 1. This gives full throughput of 1 result/cycle.
- Back-to-back acc_sel ops see the accumulator already updated by the previous accept; no bubble.
- acc_q changes only on accept or reset.
- Flags always describe the current out_z. They are registered alongside it and never computed from unregistered inputs.

Optional Feature:
- Macro: LOGIC_UNIT_PARITY_EN.
- Defined:
  - Port flag_parity exists, = XOR-reduction of the result, registered with out_z (1 = odd number of ones).
  - Reset value 0; holds on stall.
- Undefined:
  - Port flag_parity and its register are absent.
  - All other behaviour is identical.

Test Plan:
- After reset (WIDTH=8, ACC_INIT=0): out_valid=0, out_z=0x00, flags 0, acc_q=0x00, in_ready=1. Then op=000, a=0x0F, b=0xF0 accepted, out_ready=1 -> next cycle out_valid=1, out_z=0x00, flag_zero=1, flag_neg=0.
- Op sweep a=0x3C, b=0x66, one per cycle, out_ready=1 -> results:
  - AND 0x24
  - OR 0x7E
  - XOR 0x5A
  - NAND 0xDB
  - NOR 0x81
  - XNOR 0xA5
  - NOT 0xC3
  - PASS 0x66
  - flag_neg=1 for NAND, NOR, XNOR, NOT.
  - Throughput one result per cycle.
- Accumulator chain from reset:
  - op=001 acc_sel=1 b=0x81 -> out_z=0x81, acc_q=0x81.
  - next cycle op=010 acc_sel=1 b=0xFF -> out_z=0x7E, acc_q=0x7E.
  - then op=111 b=0x00 -> out_z=0x00, flag_zero=1, acc_q=0x00.
- Backpressure: result 0x24 held with out_ready=0 for 3 cycles while in_valid=1 with a=0xFF, b=0xFF, op=000 -> in_ready=0, out_z stays 0x24, acc_q unchanged. Then out_ready=1 -> same edge loads 0xFF, out_valid stays 1.
- Reset mid-operation: out_valid=1, out_z=0x7E, out_ready=0, rst=1 for one cycle with in_valid=1 -> after the edge out_valid=0, out_z=0x00, acc_q=ACC_INIT, and no transaction is accepted that cycle.
- With LOGIC_UNIT_PARITY_EN (WIDTH=8):
  - AND 0x3C/0x66 -> 0x24 gives flag_parity=0.
  - NOT 0x3C -> 0xC3 gives flag_parity=0.
  - PASS 0x07 gives flag_parity=1.
  - Repeat one case at WIDTH=16: PASS 0x8001 -> flag_parity=0, flag_neg=1.
